// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the memory stage and its MEM/WB register.
package mem_stage_sram_ctrl_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned REG_W         = 4;
    localparam int unsigned ADDR_BASE_DEF = 1024;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    // Byte address to SRAM word index; addresses below the base wrap modulo 2^32.
    function automatic logic [DATA_W-1:0] word_index(
        input logic [DATA_W-1:0] byte_addr,
        input logic [DATA_W-1:0] base
    );
        logic [DATA_W-1:0] offset;
        offset = byte_addr - base;
        return offset >> 2;
    endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_mem_wb.sv
// MEM/WB pipeline register: load, bubble (squash control bits, hold data) and sync reset.
module mem_wb_reg
    import mem_stage_sram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic              wb_en_i,
    input  logic              mem_r_en_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [REG_W-1:0]  dest_i,
    output logic              wb_en_o,
    output logic              mem_r_en_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [REG_W-1:0]  dest_o
);

    logic              wb_en_q;
    logic              mem_r_en_q;
    logic [DATA_W-1:0] alu_result_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [REG_W-1:0]  dest_q;

    // Bubble takes priority: control bits cleared, data fields left as they were.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            dest_q       <= '0;
        end else if (bubble_i) begin
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
        end else if (load_i) begin
            wb_en_q      <= wb_en_i;
            mem_r_en_q   <= mem_r_en_i;
            alu_result_q <= alu_result_i;
            mem_data_q   <= mem_data_i;
            dest_q       <= dest_i;
        end
    end

    assign wb_en_o      = wb_en_q;
    assign mem_r_en_o   = mem_r_en_q;
    assign alu_result_o = alu_result_q;
    assign mem_data_o   = mem_data_q;
    assign dest_o       = dest_q;

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: drives a fixed-latency SRAM, stalls upstream while busy, feeds MEM/WB.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no access in flight; a memory op here raises freeze at once
// ACCESS | strobe held for WAIT_CYCLES cycles, address/data stable
// DONE   | strobe dropped, load data captured; MEM/WB takes the result
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
    parameter int unsigned SRAM_ADDR_W = 16,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en_in,
    input  logic                   mem_r_en_in,
    input  logic                   mem_w_en_in,
    input  logic [DATA_W-1:0]      alu_result_in,
    input  logic [DATA_W-1:0]      val_rm_in,
    input  logic [REG_W-1:0]       dest_in,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    input  logic [DATA_W-1:0]      sram_rdata,
    output logic                   sram_we,
    output logic                   sram_re,
    output logic                   wb_en_out,
    output logic                   mem_r_en_out,
    output logic [DATA_W-1:0]      alu_result_out,
    output logic [DATA_W-1:0]      mem_data_out,
    output logic [REG_W-1:0]       dest_out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    mem_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;

    logic                   mem_en;
    logic                   rd_sel;
    logic [DATA_W-1:0]      word_idx;
    logic                   unused_word_idx;
    logic                   mwb_load;
    logic [DATA_W-1:0]      mwb_mem_data;

    assign mem_en   = mem_r_en_in | mem_w_en_in;
    // Store wins when both enables are set.
    assign rd_sel   = mem_r_en_in & ~mem_w_en_in;
    assign word_idx = word_index(alu_result_in, DATA_W'(ADDR_BASE));
    // Upper index bits beyond the SRAM width are dropped on purpose.
    assign unused_word_idx = ^word_idx;

    // State and access registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
        end
    end

    // Next-state, strobe and stall decisions.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        we_d         = we_q;
        re_d         = re_q;
        freeze       = 1'b0;
        mwb_load     = 1'b0;
        mwb_mem_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (mem_en) begin
                    freeze  = 1'b1;
                    addr_d  = word_idx[SRAM_ADDR_W-1:0];
                    wdata_d = val_rm_in;
                    we_d    = mem_w_en_in;
                    re_d    = rd_sel;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end else begin
                    mwb_load = 1'b1;
                end
            end
            ST_ACCESS: begin
                freeze = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    if (re_q) begin
                        rdata_d = sram_rdata;
                    end
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                mwb_load     = 1'b1;
                mwb_mem_data = rdata_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_we    = we_q;
    assign sram_re    = re_q;

    mem_wb_reg u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .load_i       (mwb_load),
        .bubble_i     (freeze),
        .wb_en_i      (wb_en_in),
        .mem_r_en_i   (rd_sel),
        .alu_result_i (alu_result_in),
        .mem_data_i   (mwb_mem_data),
        .dest_i       (dest_in),
        .wb_en_o      (wb_en_out),
        .mem_r_en_o   (mem_r_en_out),
        .alu_result_o (alu_result_out),
        .mem_data_o   (mem_data_out),
        .dest_o       (dest_out)
    );

endmodule
